// File: rtl/rtype_pkg.sv
// rtype_pkg: shared types, encodings and decode helpers for the R-type sequencer
// Contents:
//   alu_op_e     4-bit ALU operation code driven on alu_op
//   state_e      sequencer states
//   OPC_RTYPE / F7_BASE / F7_ALT  instruction field encodings
//   rtype_legal  legality test of a full instruction word
//   rtype_op     funct3 / funct7[5] to ALU operation mapping
package rtype_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, TRAP} state_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;

    // funct7=0x20 only selects SUB and SRA
    function automatic logic rtype_legal(input logic [31:0] ins);
        return ins[6:0] == OPC_RTYPE &&
               (ins[31:25] == F7_BASE ||
                (ins[31:25] == F7_ALT && (ins[14:12] == 3'b000 || ins[14:12] == 3'b101)));
    endfunction

    function automatic alu_op_e rtype_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return alt ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

endpackage

// File: rtl/rtype_regfile.sv
// rtype_regfile: register file with two operand read ports, one debug read port and one write port
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears every register)
//   a_addr / a_data   operand A read (combinational)
//   b_addr / b_data   operand B read (combinational)
//   d_addr / d_data   debug read (combinational)
//   we, waddr, wdata  write port; writes to register 0 are discarded
// Register 0 has no storage and always reads as zero.
module rtype_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a_addr,
    output logic [XLEN-1:0] a_data,
    input  logic [AW-1:0]   b_addr,
    output logic [XLEN-1:0] b_data,
    input  logic [AW-1:0]   d_addr,
    output logic [XLEN-1:0] d_data,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] rf [1:NREG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) rf[i] <= '0;
        end else if (we && waddr != '0) begin
            rf[waddr] <= wdata;
        end
    end

    assign a_data = a_addr == '0 ? '0 : rf[a_addr];
    assign b_data = b_addr == '0 ? '0 : rf[b_addr];
    assign d_data = d_addr == '0 ? '0 : rf[d_addr];

endmodule

// File: rtl/rtype_seq_ctrl.sv
// rtype_seq_ctrl: multi-cycle IDLE->DECODE->EXEC->WB sequencer for RV32 R-type instructions
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   instr_valid/instr_ready       instruction handshake, instruction = RV32 word
//   cfg_we/cfg_addr/cfg_wdata     register preload (honoured in IDLE only)
//   dbg_rdata                     combinational read of rf[cfg_addr]
//   alu_op/alu_a/alu_b, alu_y     external combinational ALU interface
//   wb_valid/wb_ready/wb_rd/wb_data  writeback record handshake
//   illegal                       illegal-instruction indication
//   retired                       wrapping count of retired instructions
// Build option RTYPE_CTRL_ILLEGAL_TRAP_EN: when defined an illegal decode is sticky and
// parks the sequencer in TRAP until reset; otherwise illegal pulses and the word is dropped.
module rtype_seq_ctrl
    import rtype_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instruction,
    input  logic            cfg_we,
    input  logic [4:0]      cfg_addr,
    input  logic [XLEN-1:0] cfg_wdata,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_y,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    output logic [15:0]     retired
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
`ifdef RTYPE_CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e          state, nxt;
    logic [31:0]     ir;
    logic [CW-1:0]   cnt;
    logic            legal, last, dec_ill, rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd, rs1_data, rs2_data;

    assign legal   = rtype_legal(ir);
    assign last    = cnt == CW'(ALU_LAT - 1);
    assign dec_ill = state == DECODE && !legal;

    // Result is written on the EXEC->WB edge so a following instruction reads it
    rtype_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .a_addr (ir[19:15]),
        .a_data (rs1_data),
        .b_addr (ir[24:20]),
        .b_data (rs2_data),
        .d_addr (cfg_addr),
        .d_data (dbg_rdata),
        .we     (rf_we),
        .waddr  (rf_wa),
        .wdata  (rf_wd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = instr_valid ? DECODE : IDLE;
            DECODE:  nxt = legal ? EXEC : (TRAP_EN ? TRAP : IDLE);
            EXEC:    nxt = last ? WB : EXEC;
            WB:      nxt = wb_ready ? IDLE : WB;
            TRAP:    nxt = TRAP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = state == IDLE && !rst;
        rf_we       = (state == IDLE && cfg_we) || (state == EXEC && last);
        rf_wa       = state == EXEC ? ir[11:7] : cfg_addr;
        rf_wd       = state == EXEC ? alu_y : cfg_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            cnt      <= '0;
            alu_op   <= ADD;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            illegal <= TRAP_EN ? (illegal | dec_ill) : dec_ill;
            if (state == IDLE && instr_valid) ir <= instruction;
            if (state == DECODE) begin
                cnt <= '0;
                if (legal) begin
                    alu_a  <= rs1_data;
                    alu_b  <= rs2_data;
                    alu_op <= rtype_op(ir[14:12], ir[30]);
                end
            end
            if (state == EXEC) begin
                cnt <= cnt + CW'(1);
                if (last) begin
                    wb_data  <= alu_y;
                    wb_rd    <= ir[11:7];
                    wb_valid <= 1'b1;
                    retired  <= retired + 16'd1;
                end
            end
            if (state == WB && wb_ready) wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// tb_rtype_seq_ctrl: self-checking bench for rtype_seq_ctrl with an external ALU and a reference model
module tb_rtype_seq_ctrl;
    import rtype_pkg::*;

    localparam int XLEN    = 32;
    localparam int ALU_LAT = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic            instr_ready;
    logic [31:0]     instruction = '0;
    logic            cfg_we = 1'b0;
    logic [4:0]      cfg_addr = '0;
    logic [XLEN-1:0] cfg_wdata = '0;
    logic [XLEN-1:0] dbg_rdata;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal;
    logic [15:0]     retired;

    rtype_seq_ctrl #(.XLEN(XLEN), .NREG(32), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .dbg_rdata(dbg_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // External ALU the sequencer drives
    always_comb begin
        case (alu_op)
            ADD:     alu_y = alu_a + alu_b;
            SUB:     alu_y = alu_a - alu_b;
            SLL:     alu_y = alu_a << alu_b[4:0];
            SLT:     alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            SLTU:    alu_y = {31'd0, alu_a < alu_b};
            XOR:     alu_y = alu_a ^ alu_b;
            SRL:     alu_y = alu_a >> alu_b[4:0];
            SRA:     alu_y = 32'($signed(alu_a) >>> alu_b[4:0]);
            OR:      alu_y = alu_a | alu_b;
            AND:     alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    logic [31:0] mem [32];
    int unsigned ret_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [11];

    // Architectural result of an R-type word from the model register contents
    function automatic logic [31:0] ref_result(input logic [31:0] ins);
        logic [31:0] a, b;
        logic [4:0]  sh;
        a  = mem[ins[19:15]];
        b  = mem[ins[24:20]];
        sh = b[4:0];
        case (ins[14:12])
            3'd0:    return ins[30] ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr != 0) mem[addr] = data;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ret_cnt = 0;
    endtask

    // Issue one legal instruction, hold wb_ready low for `stall` cycles, check everything
    task automatic run(input string name, input logic [31:0] ins, input int stall, output logic [31:0] got);
        logic [31:0] exp;
        logic [4:0]  rd;
        int          lat;
        exp = ref_result(ins);
        rd  = ins[11:7];
        check({name, " ready"}, 32'(instr_ready), 32'd1);
        wb_ready = (stall == 0);
        instruction = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; cfg_we = 1'b0;
        lat = 1;
        while (!wb_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, lat, 2 + ALU_LAT);
        check({name, " wb_rd"}, 32'(wb_rd), 32'(rd));
        check({name, " wb_data"}, wb_data, exp);
        got = wb_data;
        if (rd != 0) mem[rd] = exp;
        ret_cnt++;
        check({name, " retired"}, 32'(retired), 32'(ret_cnt[15:0]));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({name, " stall valid"}, 32'(wb_valid), 32'd1);
            check({name, " stall rd"}, 32'(wb_rd), 32'(rd));
            check({name, " stall data"}, wb_data, exp);
            check({name, " stall ready"}, 32'(instr_ready), 32'd0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check({name, " wb drop"}, 32'(wb_valid), 32'd0);
        check({name, " idle ready"}, 32'(instr_ready), 32'd1);
        cfg_addr = rd;
        #1;
        check({name, " rf write"}, dbg_rdata, mem[rd]);
    endtask

    task automatic issue_illegal(input string name, input logic [31:0] ins);
        instruction = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check({name, " decode"}, 32'(illegal), 32'd0);
        @(negedge clk);
        check({name, " flag"}, 32'(illegal), 32'd1);
        check({name, " no wb"}, 32'(wb_valid), 32'd0);
`ifdef RTYPE_CTRL_ILLEGAL_TRAP_EN
        check({name, " trap ready"}, 32'(instr_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1;
            @(negedge clk);
            check({name, " trap hold"}, 32'(instr_ready), 32'd0);
            check({name, " trap sticky"}, 32'(illegal), 32'd1);
            check({name, " trap wb"}, 32'(wb_valid), 32'd0);
        end
        instr_valid = 1'b0;
`else
        check({name, " back idle"}, 32'(instr_ready), 32'd1);
        @(negedge clk);
        check({name, " pulse end"}, 32'(illegal), 32'd0);
        check({name, " no wb2"}, 32'(wb_valid), 32'd0);
`endif
        check({name, " retired"}, 32'(retired), 32'(ret_cnt[15:0]));
        cfg_addr = ins[11:7];
        #1;
        check({name, " rf kept"}, dbg_rdata, mem[ins[11:7]]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, ins;
        logic [2:0]  f3;
        logic        alt;
        reset_model();
        tbl[0]  = '{32'h00118133, 32'h0000000F, 32'h0000000C, 5'd2, 32'h0000001B};
        tbl[1]  = '{32'h40118133, 32'h0000000F, 32'h0000000C, 5'd2, 32'h00000003};
        tbl[2]  = '{32'h4011D133, 32'hFF0000FF, 32'h00000004, 5'd2, 32'hFFF0000F};
        tbl[3]  = '{32'h0011D133, 32'hFF0000FF, 32'h00000004, 5'd2, 32'h0FF0000F};
        tbl[4]  = '{32'h00119133, 32'hFF0000FF, 32'h00000004, 5'd2, 32'hF0000FF0};
        tbl[5]  = '{32'h0011A133, 32'h70000000, 32'hF0000000, 5'd2, 32'h00000000};
        tbl[6]  = '{32'h0011B133, 32'h70000000, 32'hF0000000, 5'd2, 32'h00000001};
        tbl[7]  = '{32'h0011C133, 32'h0000F0F0, 32'h0000FF00, 5'd2, 32'h00000FF0};
        tbl[8]  = '{32'h0011E133, 32'h0000F0F0, 32'h0000FF00, 5'd2, 32'h0000FFF0};
        tbl[9]  = '{32'h0011F133, 32'h0000F0F0, 32'h0000FF00, 5'd2, 32'h0000F000};
        tbl[10] = '{32'h00118033, 32'h70000000, 32'hF0000000, 5'd0, 32'h60000000};

        repeat (2) @(negedge clk);
        check("rst instr_ready", 32'(instr_ready), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'(ADD));
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst wb_rd", 32'(wb_rd), 32'd0);
        check("rst wb_data", wb_data, 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst retired", 32'(retired), 32'd0);
        rst = 1'b0;
        cfg_addr = 5'd5;
        #1;
        check("post rst ready", 32'(instr_ready), 32'd1);
        check("post rst rf", dbg_rdata, 32'd0);

        for (int i = 0; i < 11; i++) begin
            preload(5'd3, tbl[i].a);
            preload(5'd1, tbl[i].b);
            run($sformatf("vec%0d", i), tbl[i].ins, 0, got);
            check($sformatf("vec%0d table", i), got, tbl[i].exp);
            check($sformatf("vec%0d rd", i), 32'(wb_rd), 32'(tbl[i].rd));
        end

        // Writeback held off for five cycles, then the next word is accepted right away
        preload(5'd3, 32'd100);
        preload(5'd1, 32'd23);
        run("stall", 32'h00118133, 5, got);
        run("after stall", 32'h40118133, 0, got);

        // Preload and accept in the same cycle: decode must see the new x3
        preload(5'd1, 32'd5);
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 32'h100;
        mem[3] = 32'h100;
        run("cfg+accept", 32'h00118133, 0, got);
        check("cfg+accept value", got, 32'h105);

        // Source equals destination of the previous instruction
        run("rs=rd a", 32'h003181B3, 0, got);
        run("rs=rd b", 32'h003181B3, 0, got);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) preload(5'($urandom_range(1, 31)), $urandom);
            f3  = 3'($urandom_range(0, 7));
            alt = (f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1;
            ins = {alt ? 7'h20 : 7'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   f3, 5'($urandom_range(0, 31)), 7'b0110011};
            run($sformatf("rnd%0d", n), ins, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, got);
        end

        // Reset in EXEC drops the instruction and clears everything
        preload(5'd3, 32'h11);
        instruction = 32'h00118133; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ready", 32'(instr_ready), 32'd0);
        check("abort wb_valid", 32'(wb_valid), 32'd0);
        check("abort retired", 32'(retired), 32'd0);
        check("abort alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        cfg_addr = 5'd3;
        #1;
        check("abort rf cleared", dbg_rdata, 32'd0);
        preload(5'd3, 32'd7);
        preload(5'd1, 32'd8);
        run("after abort", 32'h00118133, 0, got);
        check("after abort value", got, 32'd15);

`ifdef RTYPE_CTRL_ILLEGAL_TRAP_EN
        issue_illegal("itype", 32'h00118113);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        #1;
        check("trap exit ready", 32'(instr_ready), 32'd1);
        check("trap exit illegal", 32'(illegal), 32'd0);
        check("trap exit retired", 32'(retired), 32'd0);
`else
        issue_illegal("badf7", 32'h40119133);
        issue_illegal("itype", 32'h00118113);
        run("after illegal", 32'h00118133, 0, got);
        check("after illegal value", got, 32'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rtype_seq_ctrl.md
Name: rtype_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32 R-type integer datapath.
- Accepts one R-type instruction at a time over a valid/ready handshake and decodes opcode/funct3/funct7.
- Reads two operands from an internal 32x32 register file and drives an external combinational ALU.
- Captures the ALU result and writes it back, then presents a writeback record downstream.
- Sits between the instruction source (bench or future fetch unit) and the existing ALU datapath.

Parameters:
XLEN, 32, datapath width
NREG, 32, register count; x0 hardwired to zero
ALU_LAT, 1, cycles spent in EXEC before the ALU result is captured; legal values are 1 and above

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept an instruction
instruction  in  32  RV32 R-type word
cfg_we  in  1  register-file preload strobe; honoured only in IDLE
cfg_addr  in  5  preload / debug address
cfg_wdata  in  XLEN  preload data
dbg_rdata  out  XLEN  combinational read of rf[cfg_addr]
alu_op  out  4  ALU operation code (rtype_pkg::alu_op_e)
alu_a  out  XLEN  operand rs1
alu_b  out  XLEN  operand rs2
alu_y  in  XLEN  ALU result
wb_valid  out  1  writeback record valid
wb_ready  in  1  downstream accepts the record
wb_rd  out  5  destination register
wb_data  out  XLEN  result written
illegal  out  1  illegal-instruction indication
retired  out  16  count of retired instructions, wraps

Behaviour:
- Reset (async, rst=1): state IDLE; rf cleared to 0; instr_ready=0 while rst is high; alu_op=ADD; alu_a=alu_b=0; wb_valid=0; wb_rd=0; wb_data=0; illegal=0; retired=0.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instruction and go to DECODE. cfg_we writes rf[cfg_addr] (ignored for addr 0). If cfg_we and accept occur in the same cycle, the cfg write lands first and is visible to the decode.
- DECODE (1 cycle):
  - Legal means opcode=7'b0110011, funct7 in {0x00,0x20}, and funct7=0x20 only with funct3 000 or 101.
  - Legal: register rf[rs1] and rf[rs2] into alu_a/alu_b, set alu_op, go to EXEC.
  - Illegal: see the optional feature.
- Op mapping:
  - funct3 000: ADD (funct7 0x00) / SUB (0x20)
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL (0x00) / SRA (0x20)
  - 110: OR
  - 111: AND
- EXEC: hold alu_a/alu_b/alu_op stable for ALU_LAT cycles. On the last cycle, capture alu_y into wb_data and go to WB.
- WB: on WB entry, write rf[rd]=wb_data (suppressed for rd=0), assert wb_valid, and increment retired (16-bit wrap, 0xFFFF->0).
  - wb_valid, wb_rd and wb_data stay stable until wb_ready; then wb_valid=0 and state returns to IDLE.
  - Minimum accept-to-accept spacing is 3+ALU_LAT cycles, reached when wb_ready is held at 1.
- Only one instruction is in flight; no hazards. rs1/rs2 equal to the in-flight rd read the value already written.
- rst asserted mid-operation aborts immediately; the in-flight instruction is lost and not counted.

Optional Feature:
RTYPE_CTRL_ILLEGAL_TRAP_EN
- Defined: an illegal decode sets illegal=1 (sticky) and enters state TRAP.
  - In TRAP: instr_ready=0, and no rf write, wb_valid or retired update occurs.
  - Only rst leaves TRAP.
- Undefined: an illegal decode pulses illegal=1 for one cycle and returns to IDLE.
  - The instruction is dropped: no rf write, no wb_valid, retired unchanged.

Decomposition:
- Package rtype_pkg:
  - alu_op_e (4-bit): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - state_e
  - OPC_RTYPE=7'b0110011, F7_BASE=7'h00, F7_ALT=7'h20
- Sub-module rtype_regfile: 2 async read ports plus the dbg read, 1 write port muxed between the cfg and WB paths, x0 hardwired to zero.

Test Plan:
- Preload x0=0x0000000F, x1=0x0000000C is not possible for x0, so test rs1=x3, rs2=x1. Preload x3=0xF, x1=0xC; instruction 0x00118133 (add x2,x3,x1) -> wb_valid with wb_rd=2, wb_data=0x0000001B; rf[2]=0x1B; retired=1.
- Same operands with SUB (0x40118133) -> 0x00000003. Then x3=0xFF0000FF, x1=4:
  - SRA -> 0xFFF0000F
  - SRL -> 0x0FF0000F
  - SLL -> 0xF0000FF0
- x3=0x70000000, x1=0xF0000000:
  - SLT -> 0
  - SLTU -> 1
- add x0,x3,x1 -> wb_valid with wb_rd=0; dbg_rdata at cfg_addr=0 stays 0.
- Hold wb_ready=0 for 5 cycles -> wb_valid, wb_rd and wb_data stable and instr_ready=0. Release wb_ready -> next instruction accepted 1 cycle later.
- Instruction 0x00118113 (opcode I-type) -> illegal asserted and retired unchanged.
  - Trap build: instr_ready stays 0 until rst.
  - No-trap build: 1-cycle illegal pulse and a return to IDLE.
